fetch_unit: RTL and testbench

Instruction-fetch stage of the 24-bit MIPS-style core. Owns the program counter, drives the address of the combinational instruction memory, predecodes unconditional jumps (J/JAL) to redirect fetch with no bubble, and registers the fetched word into the IF/ID pipeline register consumed by decode. Accepts stall and redirect (taken branch / JR) from later stages and detects the self-loop halt idiom.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_predecode.sv | 24 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: instruction field layout,
// jump opcodes, fetch FSM states and the wrap-around PC increment helper.
package fetch_pkg;

   localparam int PC_W    = 24;
   localparam int INSTR_W = 24;

   localparam int CLASS_HI = 23;
   localparam int CLASS_LO = 22;
   localparam int OP_HI    = 21;
   localparam int OP_LO    = 17;
   localparam int TGT_HI   = 16;
   localparam int TGT_LO   = 0;

   localparam logic [1:0] CLASS_JUMP = 2'b00;

   localparam logic [4:0] OP_J   = 5'b01100;
   localparam logic [4:0] OP_JAL = 5'b01101;
   localparam logic [4:0] OP_JR  = 5'b01110;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      HALT
   } fetch_state_t;

   // Sequential address step; wraps modulo 2^PC_W by construction of the width.
   function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] pc,
                                              input int unsigned step);
      return pc + PC_W'(step);
   endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of the fetched word: spots J/JAL so fetch can follow
// them with no bubble, and flags a J that targets its own address (halt idiom).
module fetch_predecode
   import fetch_pkg::*;
(
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic [PC_W-1:0]    pc,
   output logic               is_jump,
   output logic               is_self_loop,
   output logic [PC_W-1:0]    jump_target
);

   logic [1:0] instr_class;
   logic [4:0] opcode;

   always_comb begin
      instr_class  = imem_instr[CLASS_HI:CLASS_LO];
      opcode       = imem_instr[OP_HI:OP_LO];
      jump_target  = {{(PC_W-(TGT_HI+1)){1'b0}}, imem_instr[TGT_HI:TGT_LO]};
      is_jump      = (instr_class == CLASS_JUMP) && ((opcode == OP_J) || (opcode == OP_JAL));
      is_self_loop = is_jump && (opcode == OP_J) && (jump_target == pc);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, follows J/JAL without a bubble, takes
// redirects from later stages, and fills the IF/ID register for decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 24'h000000,
   parameter int unsigned     PC_STEP  = 3,
   parameter int unsigned     COUNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [INSTR_W-1:0]  imem_instr,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [PC_W-1:0]     redirect_target,
   output logic                ifid_valid,
   output logic [INSTR_W-1:0]  ifid_instr,
   output logic [PC_W-1:0]     ifid_pc,
   output logic [PC_W-1:0]     ifid_pc_plus,
   output logic                halted,
   output logic [COUNT_W-1:0]  fetch_count
);

   fetch_state_t       state;
   fetch_state_t       state_next;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    pc_next;
   logic [PC_W-1:0]    pc_plus;
   logic               latch_en;
   logic               flush;
   logic               is_jump;
   logic               is_self_loop;
   logic [PC_W-1:0]    jump_target;
   logic [COUNT_W-1:0] count;

   assign imem_addr   = pc;
   assign pc_plus     = pc_add(pc, PC_STEP);
   assign halted      = (state == HALT);
   assign fetch_count = count;

   fetch_predecode u_predecode (
      .imem_instr   (imem_instr),
      .pc           (pc),
      .is_jump      (is_jump),
      .is_self_loop (is_self_loop),
      .jump_target  (jump_target)
   );

   // Redirect beats stall; a stalled cycle freezes everything else.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      latch_en   = 1'b0;
      flush      = 1'b0;
      if (redirect_valid) begin
         pc_next    = redirect_target;
         flush      = 1'b1;
         state_next = RUN;
      end else if (!stall) begin
         case (state)
            INIT: state_next = RUN;
            RUN: begin
               latch_en = 1'b1;
               pc_next  = is_jump ? jump_target : pc_plus;
               if (is_self_loop) begin
                  state_next = HALT;
               end
            end
            HALT: flush = 1'b1;
            default: state_next = INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   // IF/ID keeps its payload on a flush; only the valid bit is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_valid   <= 1'b0;
         ifid_instr   <= '0;
         ifid_pc      <= '0;
         ifid_pc_plus <= '0;
      end else if (latch_en) begin
         ifid_valid   <= 1'b1;
         ifid_instr   <= imem_instr;
         ifid_pc      <= pc;
         ifid_pc_plus <= pc_plus;
      end else if (flush) begin
         ifid_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (latch_en && (count != '1)) begin
         count <= count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed walk through jumps, halt, stall,
// redirect, PC wrap and async reset, then randomized traffic against a model.
module tb_fetch_unit;

   localparam logic [4:0] J_OP   = 5'b01100;
   localparam logic [4:0] JAL_OP = 5'b01101;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] imem_addr;
   logic [23:0] imem_instr;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [23:0] redirect_target = '0;
   logic        ifid_valid;
   logic [23:0] ifid_instr;
   logic [23:0] ifid_pc;
   logic [23:0] ifid_pc_plus;
   logic        halted;
   logic [15:0] fetch_count;

   int vectors = 0;
   int miscompares = 0;

   logic [23:0] mem [int];
   int          mem_gen = 0;

   bit          m_started;
   bit          m_halt;
   bit          m_v;
   int unsigned m_pc;
   int unsigned m_instr;
   int unsigned m_ipc;
   int unsigned m_iplus;
   int unsigned m_cnt;

   fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .ifid_valid      (ifid_valid),
      .ifid_instr      (ifid_instr),
      .ifid_pc         (ifid_pc),
      .ifid_pc_plus    (ifid_pc_plus),
      .halted          (halted),
      .fetch_count     (fetch_count)
   );

   always #5 clk = ~clk;

   // Unwritten locations read back as a class-01 word, which is never a jump.
   function automatic logic [23:0] memread(input logic [23:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return {2'b01, a[21:0]};
   endfunction

   always @(imem_addr or mem_gen) imem_instr = memread(imem_addr);

   function automatic logic [23:0] jmp(input logic [4:0] op, input int unsigned tgt);
      logic [16:0] t;
      t = 17'(tgt);
      return {2'b00, op, t};
   endfunction

   function automatic logic [23:0] alu(input int unsigned k);
      logic [21:0] body;
      body = 22'(k);
      return {2'b10, body};
   endfunction

   task automatic model_reset();
      m_started = 1'b0;
      m_halt    = 1'b0;
      m_v       = 1'b0;
      m_pc      = 0;
      m_instr   = 0;
      m_ipc     = 0;
      m_iplus   = 0;
      m_cnt     = 0;
   endtask

   // Next-state of the fetch stage straight from the priority rules.
   task automatic model_step();
      logic [23:0] w;
      int unsigned cls, op, tgt;
      w   = memread(24'(m_pc));
      cls = int'(w[23:22]);
      op  = int'(w[21:17]);
      tgt = int'(w[16:0]);
      if (redirect_valid) begin
         m_pc      = redirect_target;
         m_v       = 1'b0;
         m_started = 1'b1;
         m_halt    = 1'b0;
      end else if (!stall) begin
         if (!m_started) begin
            m_started = 1'b1;
         end else if (m_halt) begin
            m_v = 1'b0;
         end else begin
            m_v     = 1'b1;
            m_instr = w;
            m_ipc   = m_pc;
            m_iplus = (m_pc + 3) % 32'h0100_0000;
            if (m_cnt < 65535) m_cnt++;
            if (cls == 0 && (op == 12 || op == 13)) begin
               if (op == 12 && tgt == m_pc) m_halt = 1'b1;
               m_pc = tgt;
            end else begin
               m_pc = (m_pc + 3) % 32'h0100_0000;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input string name,
                      input logic [23:0] obs, input logic [23:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s/%s: observed %h expected %h", tag, name, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      chk(tag, "imem_addr",    imem_addr,          24'(m_pc));
      chk(tag, "ifid_valid",   24'(ifid_valid),    24'(m_v));
      chk(tag, "ifid_instr",   ifid_instr,         24'(m_instr));
      chk(tag, "ifid_pc",      ifid_pc,            24'(m_ipc));
      chk(tag, "ifid_pc_plus", ifid_pc_plus,       24'(m_iplus));
      chk(tag, "halted",       24'(halted),        24'(m_halt));
      chk(tag, "fetch_count",  24'(fetch_count),   24'(m_cnt));
   endtask

   task automatic applyStimulus(input string tag, input logic st, input logic rv,
                                input logic [23:0] rt);
      stall           = st;
      redirect_valid  = rv;
      redirect_target = rt;
      model_step();
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   // Pulse reset between clock edges and check outputs before any edge arrives.
   task automatic pulseReset(input string tag);
      stall          = 1'b0;
      redirect_valid = 1'b0;
      rst_n          = 1'b0;
      model_reset();
      #2;
      checkOutput(tag);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      model_reset();
      mem[0]  = jmp(JAL_OP, 6);
      mem[6]  = alu(1);
      mem[9]  = alu(2);
      mem[12] = alu(3);
      mem[15] = alu(4);
      mem[18] = jmp(J_OP, 3);
      mem[3]  = jmp(J_OP, 3);
      mem[24'hFFFFFE] = alu(5);
      mem_gen++;

      #3;
      checkOutput("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) applyStimulus("run", 1'b0, 1'b0, '0);
      applyStimulus("exit_halt", 1'b0, 1'b1, 24'd9);
      for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b1, 1'b0, '0);
      applyStimulus("stall_redirect", 1'b1, 1'b1, 24'd126);
      for (int i = 0; i < 3; i++) applyStimulus("after126", 1'b0, 1'b0, '0);
      applyStimulus("to_top", 1'b0, 1'b1, 24'hFFFFFE);
      for (int i = 0; i < 3; i++) applyStimulus("wrap", 1'b0, 1'b0, '0);

      pulseReset("reset_mid_run");
      for (int i = 0; i < 10; i++) applyStimulus("restart", 1'b0, 1'b0, '0);
      pulseReset("reset_in_halt");
      for (int i = 0; i < 3; i++) applyStimulus("restart2", 1'b0, 1'b0, '0);

      mem.delete();
      for (int a = 0; a < 300; a++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         if (r < 12)      mem[a] = jmp(J_OP, $urandom_range(0, 299));
         else if (r < 20) mem[a] = jmp(JAL_OP, $urandom_range(0, 299));
         else if (r < 24) mem[a] = jmp(J_OP, a);
         else             mem[a] = 24'($urandom);
      end
      mem_gen++;

      for (int i = 0; i < 500; i++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            pulseReset("rand_reset");
         end else begin
            applyStimulus("random", ($urandom_range(0, 99) < 20),
                          ($urandom_range(0, 99) < 10),
                          24'($urandom_range(0, 299)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
